// File: rtl/frame_pkg.sv
// Shared constants and state type for the frame read scheduler and line buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package frame_pkg;

  // Default geometry: 640x480 words, fetched in 16-word bursts.
  localparam int unsigned DEF_BURST_LEN   = 16;
  localparam int unsigned DEF_FRAME_WORDS = 307200;
  localparam logic [24:0] DEF_BASE0       = 25'h000000;
  localparam logic [24:0] DEF_BASE1       = 25'h080000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  // Word address of a burst inside the selected frame buffer, wrapping at 2^25.
  function automatic logic [24:0] burst_addr(input logic        sel,
                                             input logic [24:0] b0,
                                             input logic [24:0] b1,
                                             input logic [18:0] offset);
    return (sel ? b1 : b0) + {6'd0, offset};
  endfunction

endpackage

// File: rtl/sdram_read_scheduler_if.sv
// Frame-control and SDRAM burst-read signals between scheduler and its environment.
// Latency: n/a (wiring only).
// Backpressure: rd_req/rd_ready handshake; buf_full gates new requests.
// master: scheduler side (drives rd_req, rd_addr, rd_len, front_sel, drain, busy, frame_done).
// slave : environment side (drives new_frame, swap_req, buf_full, rd_ready, rd_valid).
interface sdram_read_scheduler_if;

  logic        new_frame;
  logic        swap_req;
  logic        buf_full;
  logic        rd_ready;
  logic        rd_valid;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic [5:0]  rd_len;
  logic        front_sel;
  logic        drain;
  logic        busy;
  logic        frame_done;

  modport master (
    input  new_frame, swap_req, buf_full, rd_ready, rd_valid,
    output rd_req, rd_addr, rd_len, front_sel, drain, busy, frame_done
  );

  modport slave (
    output new_frame, swap_req, buf_full, rd_ready, rd_valid,
    input  rd_req, rd_addr, rd_len, front_sel, drain, busy, frame_done
  );

endinterface

// File: rtl/sched_beat_counter.sv
// Counts returned data beats of one burst; tc flags the beat that completes it.
// Latency: tc is combinational on inc (same cycle as the final beat).
// Backpressure: none; every inc is counted, clr wins over inc.
// Ports: clk, rst_n (async active-low), clr, inc, tc.
module sched_beat_counter #(
  parameter int unsigned BURST_LEN = frame_pkg::DEF_BURST_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [4:0] LAST = 5'(BURST_LEN - 1);

  logic [4:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = inc && !clr && (count_q == LAST);

endmodule

// File: rtl/sdram_read_scheduler.sv
// Walks the front frame buffer in fixed SDRAM bursts, one burst in flight at a time.
// Latency: rd_req is combinational from state and buf_full; issue follows new_frame by one cycle.
// Backpressure: a shown rd_req holds until rd_ready; buf_full only blocks a request not yet shown.
// Ports: CLOCK_100, Reset_n (async active-low), bus (master modport of sdram_read_scheduler_if).
module sdram_read_scheduler
  import frame_pkg::*;
#(
  parameter int unsigned BURST_LEN   = frame_pkg::DEF_BURST_LEN,
  parameter int unsigned FRAME_WORDS = frame_pkg::DEF_FRAME_WORDS,
  parameter logic [24:0] BASE0       = frame_pkg::DEF_BASE0,
  parameter logic [24:0] BASE1       = frame_pkg::DEF_BASE1
) (
  input  logic                  CLOCK_100,
  input  logic                  Reset_n,
  sdram_read_scheduler_if.master bus
);

  localparam logic [18:0] FW  = 19'(FRAME_WORDS);
  localparam logic [18:0] BL  = 19'(BURST_LEN);

  sched_state_t state_q, state_d;
  logic [18:0]  offset_q, offset_d;
  logic         front_q, front_d;
  logic         swap_q, swap_d;
  logic         restart_q, restart_d;
  logic         held_q, held_d;   // request already shown, must stay until accepted

  logic rd_req;
  logic hs;
  logic beat_inc;
  logic beat_tc;

  // new_frame suppresses the request so an abort can never coincide with a handshake.
  assign rd_req   = (state_q == ST_ISSUE) && !bus.new_frame && (held_q || !bus.buf_full);
  assign hs       = rd_req && bus.rd_ready;
  assign beat_inc = (state_q == ST_WAIT) && bus.rd_valid;

  sched_beat_counter #(.BURST_LEN(BURST_LEN)) u_beat_cnt (
    .clk   (CLOCK_100),
    .rst_n (Reset_n),
    .clr   (hs),
    .inc   (beat_inc),
    .tc    (beat_tc)
  );

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    front_d   = front_q;
    swap_d    = swap_q;
    restart_d = restart_q;
    held_d    = held_q;

    case (state_q)
      ST_ISSUE: begin
        if (bus.new_frame) begin
          offset_d = '0;
          held_d   = 1'b0;
        end else if (hs) begin
          offset_d = offset_q + BL;
          held_d   = 1'b0;
          state_d  = ST_WAIT;
        end else if (rd_req) begin
          held_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (beat_tc) begin
          // A restart requested on the final beat itself needs no drain phase.
          if (restart_q || bus.new_frame) begin
            restart_d = 1'b0;
            offset_d  = '0;
            state_d   = ST_ISSUE;
          end else if (offset_q == FW) begin
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_ISSUE;
          end
        end else if (bus.new_frame) begin
          restart_d = 1'b1;
        end
      end
      default: begin
        if (bus.new_frame) begin
          offset_d = '0;
          held_d   = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
    endcase

    // A swap request in the same cycle as new_frame takes effect immediately.
    if (bus.new_frame) begin
      front_d = front_q ^ (swap_q | bus.swap_req);
      swap_d  = 1'b0;
    end else if (bus.swap_req) begin
      swap_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_100 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      offset_q  <= '0;
      front_q   <= 1'b0;
      swap_q    <= 1'b0;
      restart_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      front_q   <= front_d;
      swap_q    <= swap_d;
      restart_q <= restart_d;
      held_q    <= held_d;
    end
  end

  assign bus.rd_req     = rd_req;
  assign bus.rd_addr    = (state_q == ST_ISSUE) ? burst_addr(front_q, BASE0, BASE1, offset_q) : '0;
  assign bus.rd_len     = 6'(BURST_LEN);
  assign bus.front_sel  = front_q;
  assign bus.drain      = restart_q;
  assign bus.busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_sdram_read_scheduler.sv
// Randomized and directed bench for sdram_read_scheduler against a burst-level reference model.
// Latency: n/a (testbench).
// Backpressure: the bench plays the SDRAM controller, owing BURST_LEN beats per accepted burst.
module tb_sdram_read_scheduler;

  localparam int          TB_BL = 16;
  localparam int          TB_FW = 64;
  localparam logic [24:0] TB_B0 = 25'h000000;
  localparam logic [24:0] TB_B1 = 25'h080000;

  logic clk;
  logic rst_n;

  sdram_read_scheduler_if bus();

  sdram_read_scheduler #(
    .BURST_LEN   (TB_BL),
    .FRAME_WORDS (TB_FW),
    .BASE0       (TB_B0),
    .BASE1       (TB_B1)
  ) dut (
    .CLOCK_100 (clk),
    .Reset_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame progress in words, beats still owed by the controller.
  bit m_active, m_done, m_held, m_stale, m_front, m_swap;
  int m_words, m_left, m_frames;

  logic [24:0] hs_log[$];
  logic        obs_req, obs_drain, obs_done, obs_front;
  logic [24:0] obs_addr;

  function automatic void m_reset();
    m_active = 0; m_done = 0; m_held = 0; m_stale = 0; m_front = 0; m_swap = 0;
    m_words = 0; m_left = 0;
  endfunction

  function automatic void m_update(bit nf, bit sw, bit rdy, bit vld, bit e_req);
    bit hs;
    bit beat;
    hs   = e_req && rdy;
    beat = vld && (m_left > 0);
    if (!m_active) begin
      if (nf) begin
        m_active = 1; m_done = 0; m_words = 0; m_held = 0;
      end
    end else if (m_left == 0) begin
      if (nf) begin
        m_words = 0; m_held = 0;
      end else if (hs) begin
        m_words += TB_BL; m_left = TB_BL; m_held = 0;
      end else if (e_req) begin
        m_held = 1;
      end
    end else begin
      if (beat) m_left--;
      if (m_left == 0) begin
        if (m_stale || nf) begin
          m_stale = 0; m_words = 0;
        end else if (m_words == TB_FW) begin
          m_active = 0; m_done = 1; m_frames++;
        end
      end else if (nf) begin
        m_stale = 1;
      end
    end
    if (nf) begin
      if (m_swap || sw) m_front = !m_front;
      m_swap = 0;
    end else if (sw) begin
      m_swap = 1;
    end
  endfunction

  task automatic step(input bit nf, input bit sw, input bit bf, input bit rdy, input bit vld);
    bit          e_req;
    logic [24:0] e_addr;
    @(negedge clk);
    bus.new_frame = nf; bus.swap_req = sw; bus.buf_full = bf;
    bus.rd_ready  = rdy; bus.rd_valid = vld;
    e_req  = m_active && (m_left == 0) && !nf && (m_held || !bf);
    e_addr = (m_active && (m_left == 0)) ? ((m_front ? TB_B1 : TB_B0) + 25'(m_words)) : 25'h0;
    #1;
    chk("rd_req",     32'(bus.rd_req),     32'(e_req));
    chk("rd_addr",    32'(bus.rd_addr),    32'(e_addr));
    chk("rd_len",     32'(bus.rd_len),     32'(TB_BL));
    chk("front_sel",  32'(bus.front_sel),  32'(m_front));
    chk("drain",      32'(bus.drain),      32'(m_stale));
    chk("busy",       32'(bus.busy),       32'(m_active));
    chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    obs_req = bus.rd_req; obs_addr = bus.rd_addr; obs_drain = bus.drain;
    obs_done = bus.frame_done; obs_front = bus.front_sel;
    if (e_req && rdy) hs_log.push_back(e_addr);
    @(posedge clk);
    m_update(nf, sw, rdy, vld, e_req);
  endtask

  task automatic drive_idle();
    bus.new_frame = 0; bus.swap_req = 0; bus.buf_full = 0; bus.rd_ready = 0; bus.rd_valid = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_req"},   32'(bus.rd_req),     32'h0);
    chk({pfx, "_addr"},  32'(bus.rd_addr),    32'h0);
    chk({pfx, "_front"}, 32'(bus.front_sel),  32'h0);
    chk({pfx, "_drain"}, 32'(bus.drain),      32'h0);
    chk({pfx, "_busy"},  32'(bus.busy),       32'h0);
    chk({pfx, "_done"},  32'(bus.frame_done), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain_cnt;
    m_reset();
    m_frames = 0;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame with an always-ready controller and back-to-back beats.
    step(1, 0, 0, 0, 0);
    hs_log.delete();
    for (int i = 0; i < 600 && !obs_done; i++) step(0, 0, 0, 1, m_left > 0);
    chk("frame_done_seen", 32'(obs_done), 32'h1);
    chk("burst_count", 32'(hs_log.size()), 32'(TB_FW / TB_BL));
    chk("first_addr",  32'(hs_log.size() > 0 ? hs_log[0] : 25'h1ffffff), 32'h000000);
    chk("second_addr", 32'(hs_log.size() > 1 ? hs_log[1] : 25'h1ffffff), 32'h000010);

    // buf_full blocks a fresh request but not one already shown.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      chk("bf_block_req", 32'(obs_req), 32'h0);
    end
    step(0, 0, 0, 0, 0);
    chk("bf_shown_req", 32'(obs_req), 32'h1);
    step(0, 0, 1, 0, 0);
    chk("bf_hold_req",  32'(obs_req),  32'h1);
    chk("bf_hold_addr", 32'(obs_addr), 32'h000000);
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 40 && m_left > 0; i++) step(0, 0, 0, 0, 1);

    // new_frame after 5 of 16 beats: remaining 11 beats are flagged stale.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    drain_cnt = 0;
    for (int i = 0; i < 40 && m_left > 0; i++) begin
      step(0, 0, 0, 0, 1);
      if (obs_drain) drain_cnt++;
    end
    chk("drain_beats", 32'(drain_cnt), 32'd11);
    step(0, 0, 0, 0, 0);
    chk("drain_clear",   32'(obs_drain), 32'h0);
    chk("restart_req",   32'(obs_req),   32'h1);
    chk("restart_addr",  32'(obs_addr),  32'h000000);

    // swap_req alone leaves front_sel alone until new_frame.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("swap_hold", 32'(obs_front), 32'h0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("swap_front", 32'(obs_front), 32'h1);
    chk("swap_addr",  32'(obs_addr),  32'h080000);

    // Reset mid-WAIT: outputs clear at once, stray beats afterwards are ignored.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    // swap_req together with new_frame.
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("swap_same_front", 32'(obs_front), 32'h1);
    chk("swap_same_addr",  32'(obs_addr),  32'h080000);

    // Randomized traffic.
    m_frames = 0;
    for (int i = 0; i < 4000; i++) begin
      bit nf, sw, bf, rdy, vld;
      nf  = ($urandom_range(0, 249) == 0) || (!m_active && $urandom_range(0, 19) == 0);
      sw  = ($urandom_range(0, 149) == 0);
      bf  = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      vld = (m_left > 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      step(nf, sw, bf, rdy, vld);
    end
    chk("rand_frames_done", 32'(m_frames > 0), 32'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_read_scheduler.md
SDRAM_READ_SCHEDULER -- requirements
Module: sdram_read_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 16: words per SDRAM read burst.
REQ-002 Parameter FRAME_WORDS, default 307200: words per 640x480 frame; SHALL be a multiple of BURST_LEN.
REQ-003 Parameter BASE0, default 25'h000000: SDRAM word address of frame buffer 0.
REQ-004 Parameter BASE1, default 25'h080000: SDRAM word address of frame buffer 1.
REQ-005 CLOCK_100  in  1  system clock; all state on its rising edge.
REQ-006 Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 new_frame  in  1  one-cycle pulse marking the start of a display frame.
REQ-008 swap_req  in  1  one-cycle pulse requesting a front-buffer swap at the next new_frame.
REQ-009 buf_full  in  1  downstream line buffer almost-full.
REQ-010 rd_ready  in  1  SDRAM controller accepts a burst request this cycle.
REQ-011 rd_valid  in  1  one returned data beat from the SDRAM controller.
REQ-012 rd_req  out  1  burst read request.
REQ-013 rd_addr  out  25  burst start word address.
REQ-014 rd_len  out  6  burst length; constant BURST_LEN.
REQ-015 front_sel  out  1  buffer being scanned out (0 = BASE0, 1 = BASE1).
REQ-016 drain  out  1  beats currently returning are stale; downstream SHALL discard them.
REQ-017 busy  out  1  frame fetch in progress (ISSUE or WAIT).
REQ-018 frame_done  out  1  all FRAME_WORDS of the current frame returned.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE; one-hot or binary encoding is allowed.
REQ-020 IDLE/DONE: rd_req=0; on new_frame, load offset=0 and go to ISSUE the next cycle.
REQ-021 ISSUE: assert rd_req when buf_full=0; rd_addr = (front_sel ? BASE1 : BASE0) + offset, computed modulo 2^25.
REQ-022 Once rd_req=1, rd_req and rd_addr SHALL stay stable until rd_req&&rd_ready, even if buf_full rises. new_frame is the only exception.
REQ-023 Handshake rd_req&&rd_ready: offset += BURST_LEN, beat counter cleared, state to WAIT; rd_req drops the next cycle.
REQ-024 WAIT: each rd_valid increments the beat counter. On the BURST_LEN-th beat: go to DONE if offset==FRAME_WORDS, otherwise go to ISSUE.
REQ-025 rd_valid outside WAIT SHALL be ignored; no counter changes.
REQ-026 DONE: frame_done=1 until the next new_frame; frame_done is 0 in all other states.
REQ-027 new_frame in ISSUE: abort immediately and restart at offset 0 with the new front_sel.
REQ-028 new_frame in WAIT: set restart_pending and drain=1. When the remaining beats of that burst are drained, clear drain and restart at offset 0 in ISSUE.
REQ-029 swap_req sets swap_pending. At new_frame, front_sel toggles if swap_pending was set, or if swap_req is high in the same cycle; swap_pending then clears.
REQ-030 swap_req with no later new_frame SHALL leave front_sel unchanged indefinitely.
REQ-031 The offset counter is 19 bits and never exceeds FRAME_WORDS. The beat counter is 5 bits.
REQ-032 busy=1 in ISSUE and WAIT, including while draining.

Reset
REQ-033 Reset_n=0 SHALL immediately force: state IDLE, rd_req=0, rd_addr=0, front_sel=0, drain=0, busy=0, frame_done=0, swap_pending=0, restart_pending=0, both counters 0.
REQ-034 Reset mid-burst SHALL abandon outstanding beats; rd_valid after reset release in IDLE is ignored.

Structure
REQ-035 Package frame_pkg holds BURST_LEN, FRAME_WORDS, BASE0, BASE1 defaults and the sched_state_t enum; the line buffer shares these constants.
REQ-036 One sub-module, sched_beat_counter (clear, increment, terminal-count flag at BURST_LEN), is instantiated for the WAIT beat count.

Verification
REQ-037 Reset, then new_frame, with rd_ready=1 and 16 beats per burst -> first rd_addr=0x000000, second 0x000010; frame_done after 19200 bursts; busy high throughout.
REQ-038 swap_req, then new_frame -> front_sel=1 and first rd_addr=0x080000. swap_req and new_frame in the same cycle -> same result.
REQ-039 buf_full=1 in ISSUE -> rd_req stays 0. buf_full rising while rd_req=1 and rd_ready=0 -> rd_req held with an unchanged rd_addr.
REQ-040 new_frame after 5 of 16 beats -> drain=1 for exactly the remaining 11 beats, then rd_req with offset 0.
REQ-041 Reset_n low mid-WAIT -> all outputs 0 in the same cycle; stray rd_valid pulses after release cause no state change.
